// File: rtl/hp_cvt_int2fp_pipe.sv
// Integer (signed or unsigned) to IEEE-style float converter, three register stages.
// Latency: 3 cycles accept-to-out_valid, 1 operand per cycle when not stalled.
// Backpressure: out_ready low freezes S3; upstream stages fill bubbles, then in_ready drops.
// Optional macro HP_CVT_STICKY_FLAGS_EN adds flags_clr and sticky_inexact/sticky_overflow.
module hp_cvt_int2fp_pipe #(
    parameter int INTn = 32,
    parameter int NEXP = 8,
    parameter int NSIG = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INTn-1:0]      in_data,
    input  logic                 in_signed,
    input  logic [2:0]           in_rm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NEXP+NSIG:0]   out_data,
    output logic                 out_inexact,
    output logic                 out_overflow
`ifdef HP_CVT_STICKY_FLAGS_EN
    ,
    input  logic                 flags_clr,
    output logic                 sticky_inexact,
    output logic                 sticky_overflow
`endif
);

    localparam int LZW  = $clog2(INTn + 1);
    localparam int EW   = NEXP + LZW + 2;
    localparam int BIAS = (1 << (NEXP - 1)) - 1;
    localparam int EMAX = (1 << NEXP) - 1;
    localparam int W    = NEXP + NSIG + 1;

    // Stage 1 state: sign, magnitude, leading-zero count, rounding mode
    logic             r1_vld;
    logic             r1_sign;
    logic [INTn-1:0]  r1_abs;
    logic [LZW-1:0]   r1_lzc;
    logic [2:0]       r1_rm;

    // Stage 2 state: normalized fraction, guard/sticky, unbiased exponent
    logic             r2_vld;
    logic             r2_sign;
    logic             r2_zero;
    logic [NSIG-1:0]  r2_frac;
    logic             r2_g;
    logic             r2_s;
    logic [EW-1:0]    r2_exp;
    logic [2:0]       r2_rm;

    // Stage 3 state: packed result and flags
    logic             r3_vld;
    logic [W-1:0]     r3_dat;
    logic             r3_inx;
    logic             r3_ovf;

    logic             w_ld2;
    logic             w_ld3;
    logic             w_sign;
    logic [INTn-1:0]  w_abs;
    logic [LZW-1:0]   w_lzc;
    logic [INTn-1:0]  w_norm;
    logic             w_up;
    logic [NSIG:0]    w_sum;
    logic             w_carry;
    logic [EW-1:0]    w_bexp;
    logic [W-1:0]     w_inf;
    logic [W-1:0]     w_maxf;
    logic [W-1:0]     w_res;
    logic             w_inx;
    logic             w_ovf;

    // A stage loads when it is empty or its current contents move on this cycle.
    assign w_ld3    = r2_vld && (!r3_vld || out_ready);
    assign w_ld2    = r1_vld && (!r2_vld || w_ld3);
    assign in_ready = !rst && (!r1_vld || w_ld2);

    assign out_valid    = r3_vld;
    assign out_data     = r3_dat;
    assign out_inexact  = r3_inx;
    assign out_overflow = r3_ovf;

    // Magnitude: negation of the most negative value wraps to 2^(INTn-1), which is still the right unsigned magnitude.
    assign w_sign = in_signed & in_data[INTn-1];
    assign w_abs  = w_sign ? (~in_data + 1'b1) : in_data;

    // Leading-zero count: scanning upward, the highest set bit is the last to assign.
    always_comb begin
        w_lzc = '0;
        for (int i = 0; i < INTn; i++) begin
            if (w_abs[i]) begin
                w_lzc = LZW'(INTn - 1 - i);
            end
        end
    end

    // Shift the leading one to the MSB; an all-zero result here marks a zero operand.
    assign w_norm = r1_abs << r1_lzc;

    // Round-increment decision from guard, sticky, sign and mode (codes 5-7 behave as RNE).
    always_comb begin
        w_up = 1'b0;
        case (r2_rm)
            3'd1:    w_up = 1'b0;
            3'd2:    w_up = r2_sign & (r2_g | r2_s);
            3'd3:    w_up = ~r2_sign & (r2_g | r2_s);
            3'd4:    w_up = r2_g;
            default: w_up = r2_g & (r2_s | r2_frac[0]);
        endcase
    end

    // Fraction carry-out means the significand became 2.0: fraction wraps to zero, exponent steps up.
    assign w_sum   = {1'b0, r2_frac} + {{NSIG{1'b0}}, w_up};
    assign w_carry = w_sum[NSIG];
    assign w_bexp  = EW'(BIAS) + r2_exp + {{(EW-1){1'b0}}, w_carry};
    assign w_inf   = {r2_sign, {NEXP{1'b1}}, {NSIG{1'b0}}};
    assign w_maxf  = {r2_sign, {{(NEXP-1){1'b1}}, 1'b0}, {NSIG{1'b1}}};

    // Final packing, with zero and overflow saturation overriding the rounded value.
    always_comb begin
        w_res = {r2_sign, w_bexp[NEXP-1:0], w_sum[NSIG-1:0]};
        w_inx = r2_g | r2_s;
        w_ovf = 1'b0;
        if (r2_zero) begin
            w_res = '0;
            w_inx = 1'b0;
        end else if (w_bexp >= EW'(EMAX)) begin
            w_ovf = 1'b1;
            w_inx = 1'b1;
            case (r2_rm)
                3'd1:    w_res = w_maxf;
                3'd2:    w_res = r2_sign ? w_inf : w_maxf;
                3'd3:    w_res = r2_sign ? w_maxf : w_inf;
                default: w_res = w_inf;
            endcase
        end
    end

    // Stage 1 register: capture operand with its mode on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r1_vld  <= 1'b0;
            r1_sign <= 1'b0;
            r1_abs  <= '0;
            r1_lzc  <= '0;
            r1_rm   <= '0;
        end else if (in_ready) begin
            r1_vld <= in_valid;
            if (in_valid) begin
                r1_sign <= w_sign;
                r1_abs  <= w_abs;
                r1_lzc  <= w_lzc;
                r1_rm   <= in_rm;
            end
        end
    end

    // Stage 2 register: normalized fraction, guard/sticky and unbiased exponent.
    always_ff @(posedge clk) begin
        if (rst) begin
            r2_vld  <= 1'b0;
            r2_sign <= 1'b0;
            r2_zero <= 1'b0;
            r2_frac <= '0;
            r2_g    <= 1'b0;
            r2_s    <= 1'b0;
            r2_exp  <= '0;
            r2_rm   <= '0;
        end else if (!r2_vld || w_ld3) begin
            r2_vld <= r1_vld;
            if (w_ld2) begin
                r2_sign <= r1_sign;
                r2_zero <= ~w_norm[INTn-1];
                r2_frac <= w_norm[INTn-2 -: NSIG];
                r2_g    <= w_norm[INTn-NSIG-2];
                r2_s    <= |w_norm[INTn-NSIG-3:0];
                r2_exp  <= EW'(INTn - 1) - EW'(r1_lzc);
                r2_rm   <= r1_rm;
            end
        end
    end

    // Stage 3 register: result held unchanged while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r3_vld <= 1'b0;
            r3_dat <= '0;
            r3_inx <= 1'b0;
            r3_ovf <= 1'b0;
        end else if (!r3_vld || out_ready) begin
            r3_vld <= r2_vld;
            if (w_ld3) begin
                r3_dat <= w_res;
                r3_inx <= w_inx;
                r3_ovf <= w_ovf;
            end
        end
    end

`ifdef HP_CVT_STICKY_FLAGS_EN
    // Sticky flags: a handed-off result's flags win over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_inexact  <= 1'b0;
            sticky_overflow <= 1'b0;
        end else if (r3_vld && out_ready) begin
            sticky_inexact  <= sticky_inexact | r3_inx;
            sticky_overflow <= sticky_overflow | r3_ovf;
        end else if (flags_clr) begin
            sticky_inexact  <= 1'b0;
            sticky_overflow <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/hp_cvt_int2fp_pipe.md
HP_CVT_INT2FP_PIPE -- requirements
Module: hp_cvt_int2fp_pipe

Interface
REQ-001 SHALL have parameter INTn, default 32, integer input width (>= NSIG+3).
REQ-002 SHALL have parameter NEXP, default 8, result exponent width.
REQ-003 SHALL have parameter NSIG, default 7, result stored-fraction width (bfloat16 default).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  input operand valid.
REQ-007 SHALL have port in_ready  output  1  converter can accept an operand this cycle.
REQ-008 SHALL have port in_data  input  INTn  integer operand.
REQ-009 SHALL have port in_signed  input  1  1 = two's-complement, 0 = unsigned.
REQ-010 SHALL have port in_rm  input  3  rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM, 5-7 treated as RNE.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port out_data  output  NEXP+NSIG+1  {sign, exponent, fraction}.
REQ-014 SHALL have port out_inexact  output  1  result differs from exact value.
REQ-015 SHALL have port out_overflow  output  1  magnitude exceeded max finite before or after rounding.

Function
REQ-016 SHALL be a 3-stage pipeline: S1 registers sign, |x|, leading-zero count, rm; S2 registers normalized significand with guard and sticky bits and unbiased exponent; S3 registers rounded, packed result and flags.
REQ-017 SHALL accept a transfer when in_valid && in_ready, and emit one when out_valid && out_ready.
REQ-018 SHALL have latency exactly 3 cycles from accept to out_valid when no stall, with throughput 1 per cycle.
REQ-019 SHALL let each stage load when it is empty or its contents advance in the same cycle; in_ready = !S1_valid || S1 advances.
REQ-020 SHALL hold out_data and flags stable while out_valid && !out_ready, and SHALL NOT drop, duplicate or reorder operands.
REQ-021 SHALL sample in_signed and in_rm with in_data and carry them with the operand.
REQ-022 SHALL produce zero input as +0 (all zeros) with no flags, in either mode.
REQ-023 SHALL give sign = in_data[INTn-1] when in_signed=1, else 0; -2^(INTn-1) SHALL convert exactly.
REQ-024 SHALL use biased exponent = BIAS + (position of leading one), where BIAS = 2^(NEXP-1)-1.
REQ-025 SHALL round per in_rm using guard and sticky; a carry out of the significand increments the exponent.
REQ-026 SHALL produce on overflow (exponent >= all-ones): RNE/RMM -> +/-inf; RTZ -> max finite; RDN -> max finite for +, -inf for -; RUP -> +inf for +, max finite magnitude for -; out_overflow=1 and out_inexact=1.
REQ-027 SHALL set out_inexact=1 iff any discarded bit is nonzero or overflow occurred.

Reset
REQ-028 SHALL on rst clear all stage valids, out_valid=0, out_data=0, out_inexact=0, out_overflow=0, and in_ready=0 during the reset cycle, then 1 after.
REQ-029 SHALL discard in-flight operands when rst is asserted mid-operation; no result for them SHALL appear.

Configuration
REQ-030 SHALL, when macro HP_CVT_STICKY_FLAGS_EN is defined, add input flags_clr (1) and outputs sticky_inexact and sticky_overflow (1 each) that OR-accumulate flags of each handed-off result, are cleared by rst or flags_clr, and give accumulate priority over clear when both occur in the same cycle.
REQ-031 SHALL, without HP_CVT_STICKY_FLAGS_EN, omit those ports and registers entirely.

Verification
REQ-032 SHALL verify defaults with out_ready=1: in 1 -> 0x3F80; -1 -> 0xBF80; 0 -> 0x0000; all exact, each 3 cycles after accept.
REQ-033 SHALL verify rounding with in 257 signed: RNE -> 0x4380 inexact; RUP -> 0x4381 inexact; RTZ -> 0x4380 inexact.
REQ-034 SHALL verify extremes: signed 0x80000000 -> 0xCF00 exact; signed 0x7FFFFFFF RNE -> 0x4F00 inexact; unsigned 0xFFFFFFFF RNE -> 0x4F80 inexact.
REQ-035 SHALL verify overflow with NEXP=5, NSIG=10: in 70000 RNE -> 0x7C00; RTZ -> 0x7BFF; both overflow=1, inexact=1.
REQ-036 SHALL verify backpressure: hold out_ready=0 and offer 5 back-to-back operands; in_ready drops after 3 accepts; release yields all 5 in order, one per cycle.
REQ-037 SHALL verify reset: assert rst with 2 operands in flight; no output appears, flags clear, and the next operand converts in 3 cycles.
